// File: rtl/instr_fetch.sv
// Instruction prefetch unit: streams bytes from a combinational memory into a small FIFO
// and hands them to a consumer with valid/ready, supporting jump redirects and halt.
module instr_fetch #(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_dout,
  output logic       mem_we,
  output logic [7:0] mem_din,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       jump_en,
  input  logic [7:0] jump_addr,
  input  logic       halt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t        state_reg;
  logic [7:0]    fpc_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [7:0]    buf_instr [DEPTH];
  logic [7:0]    buf_pc    [DEPTH];
  logic [7:0]    last_instr_reg;
  logic [7:0]    last_pc_reg;

  logic has_entry;
  logic pop;
  logic push;

  assign has_entry = (count_reg != '0);
  // A jump flushes the buffer, so it also suppresses the consumer transfer.
  assign pop  = has_entry & instr_ready & ~jump_en;
  assign push = (state_reg == RUN) & ~jump_en & ~halt & ((count_reg != FULL) | pop);

  assign mem_addr    = fpc_reg;
  assign mem_we      = 1'b0;
  assign mem_din     = 8'h00;
  assign instr_valid = has_entry & ~reset;
  assign instr       = has_entry ? buf_instr[rd_ptr_reg] : last_instr_reg;
  assign instr_pc    = has_entry ? buf_pc[rd_ptr_reg]    : last_pc_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr_reg] <= mem_dout;
      buf_pc[wr_ptr_reg]    <= fpc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= RUN;
      fpc_reg        <= RESET_PC;
      count_reg      <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      last_instr_reg <= 8'h00;
      last_pc_reg    <= 8'h00;
    end else begin
      // Remember what was last shown so the outputs hold steady once the buffer drains.
      if (has_entry) begin
        last_instr_reg <= buf_instr[rd_ptr_reg];
        last_pc_reg    <= buf_pc[rd_ptr_reg];
      end
      if (jump_en) begin
        state_reg  <= RUN;
        fpc_reg    <= jump_addr;
        count_reg  <= '0;
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else begin
        if (push) begin
          fpc_reg    <= fpc_reg + 8'd1;
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
        if (halt) begin
          state_reg <= HALTED;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic against a queue model.
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       reset2 = 1'b1;
  logic [7:0] mem_addr, mem_dout, mem_din, instr, instr_pc;
  logic       mem_we, instr_valid;
  logic       instr_ready = 1'b0;
  logic       jump_en = 1'b0;
  logic [7:0] jump_addr = 8'h00;
  logic       halt = 1'b0;
  logic [7:0] mem_addr2, mem_dout2, mem_din2, instr2, instr_pc2;
  logic       mem_we2, instr_valid2;

  logic [7:0] mem [256];
  assign mem_dout  = mem[mem_addr];
  assign mem_dout2 = mem[mem_addr2];

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_we(mem_we), .mem_din(mem_din), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .jump_en(jump_en),
    .jump_addr(jump_addr), .halt(halt)
  );

  instr_fetch #(.DEPTH(2), .RESET_PC(8'hFE)) dut_fe (
    .clk(clk), .reset(reset2), .mem_addr(mem_addr2), .mem_dout(mem_dout2),
    .mem_we(mem_we2), .mem_din(mem_din2), .instr(instr2), .instr_pc(instr_pc2),
    .instr_valid(instr_valid2), .instr_ready(1'b1), .jump_en(1'b0),
    .jump_addr(8'h00), .halt(1'b0)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: buffered {pc, byte} entries, fetch pointer and halted flag.
  logic [15:0] mq[$];
  logic [7:0]  m_fpc = 8'h00;
  bit          m_halted = 1'b0;
  logic [15:0] got[$];

  function automatic logic [24:0] dut_view();
    return {instr_valid, instr_valid ? {instr_pc, instr} : 16'h0000, mem_addr};
  endfunction

  function automatic logic [24:0] model_view();
    return {mq.size() != 0, (mq.size() != 0) ? mq[0] : 16'h0000, m_fpc};
  endfunction

  task automatic model_edge();
    bit popv;
    bit pushv;
    if (reset) begin
      mq.delete();
      m_fpc = 8'h00;
      m_halted = 1'b0;
    end else if (jump_en) begin
      mq.delete();
      m_fpc = jump_addr;
      m_halted = 1'b0;
    end else begin
      popv  = (mq.size() > 0) && instr_ready;
      pushv = !m_halted && !halt && ((mq.size() < DEPTH) || popv);
      if (popv) void'(mq.pop_front());
      if (pushv) begin
        mq.push_back({m_fpc, mem[m_fpc]});
        m_fpc = m_fpc + 8'd1;
      end
      if (halt) m_halted = 1'b1;
    end
  endtask

  task automatic tick();
    if (instr_valid && instr_ready && !reset) got.push_back({instr_pc, instr});
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart();
    reset = 1'b1; jump_en = 1'b0; halt = 1'b0; instr_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      reset = 1'b1;
      instr_ready = 1'($urandom); halt = 1'($urandom); jump_en = 1'($urandom);
      jump_addr = 8'($urandom);
      tick();
      n_checks++;
      if ({instr_valid, mem_addr, mem_we, mem_din} !== {1'b0, 8'h00, 1'b0, 8'h00})
        $display("FAIL reset[%0d]: got valid=%b addr=%h we=%b din=%h, expected 0/00/0/00",
                 i, instr_valid, mem_addr, mem_we, mem_din);
      else n_pass++;
    end
    jump_en = 1'b0; halt = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0021; exp_seq[1] = 16'h0138; exp_seq[2] = 16'h0230;
    restart();
    instr_ready = 1'b1;
    n_checks++;
    if (instr_valid !== 1'b0) $display("FAIL basic_release: valid=%b expected 0", instr_valid);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, exp_seq[i]})
        $display("FAIL basic[%0d]: got valid=%b pc=%h instr=%h, expected 1 %h",
                 i, instr_valid, instr_pc, instr, exp_seq[i]);
      else n_pass++;
      n_checks++;
      if (dut_view() !== model_view())
        $display("FAIL basic_model[%0d]: got %h expected %h", i, dut_view(), model_view());
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    restart();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 1) begin
        n_checks++;
        if ({instr_valid, mem_addr, instr_pc, instr} !== {1'b1, 8'h02, 8'h00, 8'h21})
          $display("FAIL stall[%0d]: got valid=%b addr=%h pc=%h instr=%h, expected 1/02/00/21",
                   i, instr_valid, mem_addr, instr_pc, instr);
        else n_pass++;
      end
    end
    got.delete();
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && got.size() < 3; i++) tick();
    n_checks++;
    if (got.size() < 3) $display("FAIL stall_drain: got %0d transfers, expected 3", got.size());
    else if ({got[0], got[1], got[2]} !== {16'h0021, 16'h0138, 16'h0230})
      $display("FAIL stall_drain: got %h %h %h, expected 0021 0138 0230", got[0], got[1], got[2]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] pcs [4];
    pcs[0] = 8'hFE; pcs[1] = 8'hFF; pcs[2] = 8'h00; pcs[3] = 8'h01;
    reset2 = 1'b1;
    tick();
    n_checks++;
    if ({instr_valid2, mem_addr2} !== {1'b0, 8'hFE})
      $display("FAIL wrap_reset: got valid=%b addr=%h, expected 0/fe", instr_valid2, mem_addr2);
    else n_pass++;
    reset2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({instr_valid2, instr_pc2, instr2} !== {1'b1, pcs[i], mem[pcs[i]]})
        $display("FAIL wrap[%0d]: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                 i, instr_valid2, instr_pc2, instr2, pcs[i], mem[pcs[i]]);
      else n_pass++;
    end
  endtask

  task automatic test_jump_full();
    restart();
    for (int i = 0; i < 3; i++) tick();
    jump_en = 1'b1; jump_addr = 8'h40;
    tick();
    jump_en = 1'b0;
    n_checks++;
    if ({instr_valid, mem_addr} !== {1'b0, 8'h40})
      $display("FAIL jump_flush: got valid=%b addr=%h, expected 0/40", instr_valid, mem_addr);
    else n_pass++;
    instr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 8'(8'h40 + i), mem[8'h40 + i]})
        $display("FAIL jump_fetch[%0d]: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                 i, instr_valid, instr_pc, instr, 8'(8'h40 + i), mem[8'h40 + i]);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    restart();
    tick(); tick();
    got.delete();
    halt = 1'b1; instr_ready = 1'b1;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (dut_view() !== model_view())
        $display("FAIL halt_model[%0d]: got %h expected %h", i, dut_view(), model_view());
      else n_pass++;
    end
    n_checks++;
    if (got.size() != 2) $display("FAIL halt_drain: got %0d transfers, expected 2", got.size());
    else if ({got[0], got[1]} !== {16'h0021, 16'h0138})
      $display("FAIL halt_drain: got %h %h, expected 0021 0138", got[0], got[1]);
    else n_pass++;
    n_checks++;
    if ({instr_valid, mem_addr} !== {1'b0, 8'h02})
      $display("FAIL halt_frozen: got valid=%b addr=%h, expected 0/02", instr_valid, mem_addr);
    else n_pass++;
    jump_en = 1'b1; jump_addr = 8'h10;
    tick();
    jump_en = 1'b0;
    tick();
    n_checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 8'h10, mem[8'h10]})
      $display("FAIL halt_resume: got valid=%b pc=%h instr=%h, expected 1 10 %h",
               instr_valid, instr_pc, instr, mem[8'h10]);
    else n_pass++;
  endtask

  task automatic test_halt_jump();
    restart();
    instr_ready = 1'b1;
    halt = 1'b1;
    tick();
    halt = 1'b1; jump_en = 1'b1; jump_addr = 8'h80;
    tick();
    halt = 1'b0; jump_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({instr_valid, instr_pc} !== {1'b1, 8'(8'h80 + i)})
        $display("FAIL halt_jump[%0d]: got valid=%b pc=%h, expected 1 %h",
                 i, instr_valid, instr_pc, 8'(8'h80 + i));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      jump_en     = ($urandom_range(0, 11) == 0);
      halt        = ($urandom_range(0, 14) == 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      jump_addr   = 8'($urandom);
      tick();
      n_checks++;
      if ({dut_view(), mem_we, mem_din} !== {model_view(), 1'b0, 8'h00})
        $display("FAIL random[%0d]: got %h we=%b din=%h, expected %h we=0 din=00",
                 i, dut_view(), mem_we, mem_din, model_view());
      else n_pass++;
    end
    reset = 1'b0; jump_en = 1'b0; halt = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h21; mem[1] = 8'h38; mem[2] = 8'h30;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_jump_full();
    test_halt();
    test_halt_jump();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
